// File: rtl/seq_det_pkg.sv
// Shared constants for the sequenced running-parity arbiter: FSM state encoding and
// default sizing.
package seq_det_pkg;

  localparam int unsigned DEF_N_REQ  = 4;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_parity_core.sv
// Shared serial Mealy running-parity detector: dout = s ^ din, s accumulates while enabled.
// Clear wins over enable.
module serial_parity_core (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_din,
  output logic o_dout
);

  logic r_s;

  assign o_dout = r_s ^ i_din;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_s <= 1'b0;
    end else if (i_clr) begin
      r_s <= 1'b0;
    end else if (i_en) begin
      r_s <= r_s ^ i_din;
    end
  end

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter/sequencer feeding granted words LSB-first through one shared parity
// detector. Define SEQ_DET_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module seq_det_arbiter
  import seq_det_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned ID_W  = $clog2(N_REQ),
  localparam int unsigned CNT_W = $clog2(DATA_W)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_gnt,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [ID_W-1:0]         o_done_id,
  output logic [DATA_W-1:0]       o_result,
  output logic                    o_parity
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(DATA_W - 1);

  state_t              r_state;
  logic [N_REQ-1:0]    r_gnt;
  logic                r_busy;
  logic                r_done;
  logic [ID_W-1:0]     r_done_id;
  logic [ID_W-1:0]     r_cur_id;
  logic [DATA_W-1:0]   r_result;
  logic                r_parity;
  logic [DATA_W-1:0]   r_shreg;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_start;
  logic                w_shift_en;
  logic                w_dout;
  logic [ID_W-1:0]     w_winner;
  logic [DATA_W-1:0]   w_sel_data;

  assign w_start    = (r_state == IDLE) && (|i_req);
  assign w_shift_en = (r_state == SHIFT);

`ifdef SEQ_DET_ARB_FIXED_PRIO_EN
  logic w_found;

  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (i_req[i] && !w_found) begin
        w_winner = ID_W'(i);
        w_found  = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] r_last;
  int unsigned     w_dist;
  int unsigned     w_best;

  // Distance 0 is the slot right after the last winner; smallest distance wins.
  always_comb begin
    w_winner = '0;
    w_dist   = '0;
    w_best   = N_REQ;
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_dist = (32'(i) + N_REQ - 1 - 32'(r_last)) % N_REQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_winner = ID_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_last <= ID_W'(N_REQ - 1);
    end else if (w_start) begin
      r_last <= w_winner;
    end
  end
`endif

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_winner == ID_W'(i)) begin
        w_sel_data = i_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  serial_parity_core u_core (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_start),
    .i_en   (w_shift_en),
    .i_din  (r_shreg[0]),
    .o_dout (w_dout)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_cur_id  <= '0;
      r_result  <= '0;
      r_parity  <= 1'b0;
      r_shreg   <= '0;
      r_cnt     <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_shreg  <= w_sel_data;
            r_gnt    <= N_REQ'(1) << w_winner;
            r_busy   <= 1'b1;
            r_cur_id <= w_winner;
            r_cnt    <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_shreg  <= r_shreg >> 1;
          r_result <= {w_dout, r_result[DATA_W-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LastBit) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_done_id <= r_cur_id;
            r_parity  <= w_dout;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_done_id = r_done_id;
  assign o_result  = r_result;
  assign o_parity  = r_parity;

endmodule
